// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared definitions for the AXI4-Lite memory slave: response codes,
// write/read FSM state encodings and the byte-address to word-index helper.
package axi_lite_mem_slave_pkg;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Drops the byte-lane bits so unaligned addresses fold onto their word.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input int          data_width);
    return (data_width == 64) ? (byte_addr >> 3) : (byte_addr >> 2);
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between the upstream bus port and the memory slave.
interface axi_lite_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic                    s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic                    s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/axi_lite_mem_array.sv
// Word storage with per-byte write enables, a registered read port and an
// asynchronous clear of every word.
module axi_lite_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic                    rd_in_range,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte-lane write into the addressed word; reset wipes the whole array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Registered read; a write on the same edge is not yet visible here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a word-addressed memory. Independent write and
// read FSMs; out-of-range accesses answer SLVERR without touching storage.
module axi_lite_mem_slave
  import axi_lite_mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 16
) (
  input logic                 s_axi_aclk,
  input logic                 s_axi_aresetn,
  axi_lite_mem_slave_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;

  logic awready_q, awready_n, wready_q, wready_n;
  logic aw_held, aw_held_n, w_held, w_held_n;
  logic bresp_q, bresp_n;
  logic arready_q, arready_n, rresp_q, rresp_n;

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  logic                  wr_in_range, rd_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [31:0]           wr_idx, rd_idx;

  // Handshakes, payload selection (live or latched) and address decode.
  always_comb begin
    aw_hs       = bus.s_axi_awvalid & awready_q;
    w_hs        = bus.s_axi_wvalid & wready_q;
    ar_hs       = bus.s_axi_arvalid & arready_q;
    wr_addr     = aw_hs ? bus.s_axi_awaddr : awaddr_q;
    wr_data     = w_hs ? bus.s_axi_wdata : wdata_q;
    wr_strb     = w_hs ? bus.s_axi_wstrb : wstrb_q;
    wr_idx      = word_index(32'(wr_addr), DATA_WIDTH);
    rd_idx      = word_index(32'(bus.s_axi_araddr), DATA_WIDTH);
    wr_in_range = wr_idx < 32'(MEM_DEPTH);
    rd_in_range = rd_idx < 32'(MEM_DEPTH);
    wr_commit   = (wr_state == WR_IDLE) & (aw_hs | aw_held) & (w_hs | w_held);
  end

  // Write FSM: collect AW and W in any order, commit, then hold B until taken.
  always_comb begin
    wr_state_n = wr_state;
    awready_n  = awready_q;
    wready_n   = wready_q;
    aw_held_n  = aw_held;
    w_held_n   = w_held;
    bresp_n    = bresp_q;
    case (wr_state)
      WR_IDLE: begin
        if (wr_commit) begin
          wr_state_n = WR_RESP;
          awready_n  = 1'b0;
          wready_n   = 1'b0;
          aw_held_n  = 1'b0;
          w_held_n   = 1'b0;
          bresp_n    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          aw_held_n = aw_held | aw_hs;
          w_held_n  = w_held | w_hs;
          awready_n = ~(aw_held | aw_hs);
          wready_n  = ~(w_held | w_hs);
        end
      end
      WR_RESP: begin
        if (bus.s_axi_bready) begin
          wr_state_n = WR_IDLE;
          awready_n  = 1'b1;
          wready_n   = 1'b1;
        end
      end
    endcase
  end

  // Write FSM state, readies, pending flags and latched payload.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state  <= WR_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wr_state  <= wr_state_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      bresp_q   <= bresp_n;
      if (aw_hs) awaddr_q <= bus.s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= bus.s_axi_wdata;
        wstrb_q <= bus.s_axi_wstrb;
      end
    end
  end

  // Read FSM: accept AR in idle, present registered data until taken.
  always_comb begin
    rd_state_n = rd_state;
    arready_n  = arready_q;
    rresp_n    = rresp_q;
    case (rd_state)
      RD_IDLE: begin
        arready_n = 1'b1;
        if (ar_hs) begin
          rd_state_n = RD_DATA;
          arready_n  = 1'b0;
          rresp_n    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      RD_DATA: begin
        if (bus.s_axi_rready) begin
          rd_state_n = RD_IDLE;
          arready_n  = 1'b1;
        end
      end
    endcase
  end

  // Read FSM state, ready and response registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state  <= RD_IDLE;
      arready_q <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rd_state  <= rd_state_n;
      arready_q <= arready_n;
      rresp_q   <= rresp_n;
    end
  end

  axi_lite_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .wr_en      (wr_commit & wr_in_range),
    .wr_idx     (wr_idx[IDX_W-1:0]),
    .wr_strb    (wr_strb),
    .wr_data    (wr_data),
    .rd_en      (ar_hs),
    .rd_in_range(rd_in_range),
    .rd_idx     (rd_idx[IDX_W-1:0]),
    .rd_data    (bus.s_axi_rdata)
  );

  assign bus.s_axi_awready = awready_q;
  assign bus.s_axi_wready  = wready_q;
  assign bus.s_axi_bvalid  = (wr_state == WR_RESP);
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_arready = arready_q;
  assign bus.s_axi_rvalid  = (rd_state == RD_DATA);
  assign bus.s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: a small memory model produces the
// expected B/R responses, queued at issue time and popped on DUT output.
module tb_axi_lite_mem_slave;
  import axi_lite_mem_slave_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          resp;
  } rd_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic          exp_b_q [$];
  rd_exp_t       exp_r_q [$];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  axi_lite_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_mem_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .bus          (bus)
  );

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endfunction

  function automatic logic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                       input logic [DW/8-1:0] strb);
    int idx;
    idx = int'(addr) >> 2;
    if (idx >= DEPTH) return RESP_SLVERR;
    for (int b = 0; b < DW/8; b++) if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
    return RESP_OKAY;
  endfunction

  function automatic rd_exp_t model_read(input logic [AW-1:0] addr);
    rd_exp_t e;
    int idx;
    idx = int'(addr) >> 2;
    if (idx >= DEPTH) begin
      e.data = '0;
      e.resp = RESP_SLVERR;
    end else begin
      e.data = model_mem[idx];
      e.resp = RESP_OKAY;
    end
    return e;
  endfunction

  function automatic logic pop_b();
    if (exp_b_q.size() == 0) return 1'bx;
    return exp_b_q.pop_front();
  endfunction

  function automatic rd_exp_t pop_r();
    if (exp_r_q.size() == 0) return 'x;
    return exp_r_q.pop_front();
  endfunction

  // Drives AW and W together from a negedge; returns at the negedge after acceptance.
  task automatic issue_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, output bit ok);
    ok = 1'b0;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_wdata   = data;
    bus.s_axi_wstrb   = strb;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (bus.s_axi_awready && bus.s_axi_wready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      exp_b_q.push_back(model_write(addr, data, strb));
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] addr, output bit ok);
    ok = 1'b0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (bus.s_axi_arready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      exp_r_q.push_back(model_read(addr));
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_axi_arvalid = 1'b0;
  endtask

  // Waits (bounded) for bvalid, samples bresp, then completes the handshake.
  task automatic collect_b(output bit got, output logic resp, output int waited);
    got    = 1'b0;
    waited = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.s_axi_bvalid) begin
        got = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    resp = bus.s_axi_bresp;
    if (got) begin
      bus.s_axi_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_axi_bready = 1'b0;
    end
  endtask

  task automatic collect_r(output bit got, output rd_exp_t act, output int waited);
    got    = 1'b0;
    waited = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.s_axi_rvalid) begin
        got = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    act.data = bus.s_axi_rdata;
    act.resp = bus.s_axi_rresp;
    if (got) begin
      bus.s_axi_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_axi_rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit ok, got;
    int waited;
    rd_exp_t act, exp;
    logic [DW+6:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_bresp,
            bus.s_axi_arready, bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h required 0", outs);
    end
    rst_n = 1'b1;
    vectors++;
    if ({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL ready_before_edge: got %b required 000",
               {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready});
    end
    @(negedge clk);
    vectors++;
    if ({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL ready_after_release: got %b required 111",
               {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready});
    end
    issue_read(8'h00, ok);
    collect_r(got, act, waited);
    exp = pop_r();
    vectors++;
    if (!ok || !got || act !== exp) begin
      miscompares++;
      $display("[TB] FAIL reset_read0: got ok=%0d rvalid=%0d data=%h resp=%b required data=%h resp=%b",
               ok, got, act.data, act.resp, exp.data, exp.resp);
    end
  endtask

  task automatic test_aligned();
    bit ok, got;
    int waited;
    logic resp, eb;
    rd_exp_t act, exp;
    issue_write(8'h08, 32'hDEADBEEF, 4'hF, ok);
    collect_b(got, resp, waited);
    eb = pop_b();
    vectors++;
    if (!ok || !got || waited != 0 || resp !== eb) begin
      miscompares++;
      $display("[TB] FAIL aligned_write: got ok=%0d bvalid=%0d wait=%0d bresp=%b required wait=0 bresp=%b",
               ok, got, waited, resp, eb);
    end
    issue_read(8'h08, ok);
    collect_r(got, act, waited);
    exp = pop_r();
    vectors++;
    if (!ok || !got || waited != 0 || act !== exp) begin
      miscompares++;
      $display("[TB] FAIL aligned_read: got wait=%0d data=%h resp=%b required wait=0 data=%h resp=%b",
               waited, act.data, act.resp, exp.data, exp.resp);
    end
  endtask

  task automatic test_strobe_order();
    bit ok, got;
    int waited;
    logic resp, eb;
    rd_exp_t act, exp;
    bus.s_axi_wdata  = 32'h11223344;
    bus.s_axi_wstrb  = 4'h5;
    bus.s_axi_wvalid = 1'b1;
    vectors++;
    if (bus.s_axi_wready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL strobe_wready_idle: got %b required 1", bus.s_axi_wready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (bus.s_axi_wready !== 1'b0 || bus.s_axi_awready !== 1'b1 || bus.s_axi_bvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL strobe_wait_aw%0d: got wready=%b awready=%b bvalid=%b required 0 1 0",
                 c, bus.s_axi_wready, bus.s_axi_awready, bus.s_axi_bvalid);
      end
      if (c < 2) @(negedge clk);
    end
    bus.s_axi_awaddr  = 8'h08;
    bus.s_axi_awvalid = 1'b1;
    exp_b_q.push_back(model_write(8'h08, 32'h11223344, 4'h5));
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    collect_b(got, resp, waited);
    eb = pop_b();
    vectors++;
    if (!got || waited != 0 || resp !== eb) begin
      miscompares++;
      $display("[TB] FAIL strobe_b: got bvalid=%0d wait=%0d bresp=%b required wait=0 bresp=%b",
               got, waited, resp, eb);
    end
    issue_read(8'h08, ok);
    collect_r(got, act, waited);
    exp = pop_r();
    vectors++;
    if (!ok || !got || act !== exp) begin
      miscompares++;
      $display("[TB] FAIL strobe_read: got data=%h resp=%b required data=%h resp=%b",
               act.data, act.resp, exp.data, exp.resp);
    end
  endtask

  task automatic test_backpressure();
    bit ok, okr, got;
    int waited;
    logic resp, eb;
    rd_exp_t act, exp;
    issue_write(8'h0C, 32'h12345678, 4'hF, ok);
    issue_read(8'h08, okr);
    bus.s_axi_awaddr  = 8'h10;
    bus.s_axi_wdata   = 32'hFFFF0000;
    bus.s_axi_wstrb   = 4'hF;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    bus.s_axi_araddr  = 8'h0C;
    bus.s_axi_arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      eb  = (exp_b_q.size() != 0) ? exp_b_q[0] : 1'bx;
      exp = (exp_r_q.size() != 0) ? exp_r_q[0] : 'x;
      vectors++;
      if (!ok || !okr || bus.s_axi_bvalid !== 1'b1 || bus.s_axi_bresp !== eb ||
          bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rresp !== exp.resp || bus.s_axi_rdata !== exp.data ||
          {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold%0d: got bv=%b br=%b rv=%b rr=%b rd=%h rdy=%b required 1 %b 1 %b %h 000",
                 c, bus.s_axi_bvalid, bus.s_axi_bresp, bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata,
                 {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, eb, exp.resp, exp.data);
      end
      @(negedge clk);
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    collect_b(got, resp, waited);
    eb = pop_b();
    vectors++;
    if (!got || resp !== eb || bus.s_axi_bvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_b: got bvalid=%0d bresp=%b after=%b required bresp=%b after=0",
               got, resp, bus.s_axi_bvalid, eb);
    end
    collect_r(got, act, waited);
    exp = pop_r();
    vectors++;
    if (!got || act !== exp || bus.s_axi_rvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_r: got data=%h resp=%b after=%b required data=%h resp=%b after=0",
               act.data, act.resp, bus.s_axi_rvalid, exp.data, exp.resp);
    end
  endtask

  task automatic test_error();
    bit ok, got;
    int waited;
    logic resp, eb;
    rd_exp_t act, exp;
    logic [AW-1:0] raddr [3];
    issue_write(8'h40, 32'hFFFFFFFF, 4'hF, ok);
    collect_b(got, resp, waited);
    eb = pop_b();
    vectors++;
    if (!ok || !got || resp !== eb) begin
      miscompares++;
      $display("[TB] FAIL error_bresp: got bvalid=%0d bresp=%b required bresp=%b", got, resp, eb);
    end
    raddr[0] = 8'h00;
    raddr[1] = 8'h0C;
    raddr[2] = 8'hFC;
    for (int i = 0; i < 3; i++) begin
      issue_read(raddr[i], ok);
      collect_r(got, act, waited);
      exp = pop_r();
      vectors++;
      if (!ok || !got || act !== exp) begin
        miscompares++;
        $display("[TB] FAIL error_read_%h: got data=%h resp=%b required data=%h resp=%b",
                 raddr[i], act.data, act.resp, exp.data, exp.resp);
      end
    end
  endtask

  task automatic test_collision();
    bit ok, got;
    int waited;
    logic resp, eb;
    rd_exp_t act, exp;
    for (int n = 0; n < 20; n++) begin
      if (bus.s_axi_awready && bus.s_axi_wready && bus.s_axi_arready) break;
      @(negedge clk);
    end
    bus.s_axi_awaddr  = 8'h04;
    bus.s_axi_wdata   = 32'hA5A5A5A5;
    bus.s_axi_wstrb   = 4'hF;
    bus.s_axi_araddr  = 8'h04;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    bus.s_axi_arvalid = 1'b1;
    exp_r_q.push_back(model_read(8'h04));
    exp_b_q.push_back(model_write(8'h04, 32'hA5A5A5A5, 4'hF));
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    collect_b(got, resp, waited);
    eb = pop_b();
    vectors++;
    if (!got || resp !== eb) begin
      miscompares++;
      $display("[TB] FAIL collision_b: got bvalid=%0d bresp=%b required bresp=%b", got, resp, eb);
    end
    collect_r(got, act, waited);
    exp = pop_r();
    vectors++;
    if (!got || act !== exp) begin
      miscompares++;
      $display("[TB] FAIL collision_old: got data=%h resp=%b required data=%h resp=%b",
               act.data, act.resp, exp.data, exp.resp);
    end
    issue_read(8'h04, ok);
    collect_r(got, act, waited);
    exp = pop_r();
    vectors++;
    if (!ok || !got || act !== exp) begin
      miscompares++;
      $display("[TB] FAIL collision_new: got data=%h resp=%b required data=%h resp=%b",
               act.data, act.resp, exp.data, exp.resp);
    end
  endtask

  task automatic test_reset_abort();
    bit ok, got;
    int waited;
    rd_exp_t act, exp;
    logic [AW-1:0] raddr [2];
    issue_write(8'h0C, 32'hCAFEF00D, 4'hF, ok);
    vectors++;
    if (!ok || bus.s_axi_bvalid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_pending: got ok=%0d bvalid=%b required bvalid=1", ok, bus.s_axi_bvalid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.s_axi_bvalid, bus.s_axi_bresp, bus.s_axi_awready, bus.s_axi_wready} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL abort_bvalid_drop: got %b required 0000",
               {bus.s_axi_bvalid, bus.s_axi_bresp, bus.s_axi_awready, bus.s_axi_wready});
    end
    exp_b_q.delete();
    exp_r_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    raddr[0] = 8'h0C;
    raddr[1] = 8'h04;
    for (int i = 0; i < 2; i++) begin
      issue_read(raddr[i], ok);
      collect_r(got, act, waited);
      exp = pop_r();
      vectors++;
      if (!ok || !got || act !== exp) begin
        miscompares++;
        $display("[TB] FAIL abort_cleared_%h: got data=%h resp=%b required data=%h resp=%b",
                 raddr[i], act.data, act.resp, exp.data, exp.resp);
      end
    end
  endtask

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    bus.s_axi_awaddr  = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready  = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_aligned();
    test_strobe_order();
    test_backpressure();
    test_error();
    test_collision();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- AXI4-Lite slave endpoint that sits directly downstream of the bus block's m1 master port and consumes every m1 transaction.
- Backs the port with a word-addressed register/memory array of MEM_DEPTH x DATA_WIDTH.
- Independent write and read channels, byte strobes, and a 1-bit response: 0 = OKAY, 1 = SLVERR.
- Serves as the bench/system target for bus-level traffic.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDR_WIDTH, 8, byte address width, matching the bus.
- MEM_DEPTH, 16, number of DATA_WIDTH words; a power of 2, at most 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).

Ports:
- s_axi_aclk  in  1  clock, all logic on the rising edge
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write byte address
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write address handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables; bit i covers byte i
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write data handshake
- s_axi_bresp  out  1  write response (0 OKAY, 1 SLVERR)
- s_axi_bvalid  out  1 / s_axi_bready  in  1  write response handshake
- s_axi_araddr  in  ADDR_WIDTH  read byte address
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read address handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  1  read response (0 OKAY, 1 SLVERR)
- s_axi_rvalid  out  1 / s_axi_rready  in  1  read data handshake

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While s_axi_aresetn=0, all outputs are 0, including the readies, bresp, rresp and rdata.
  - Memory array is cleared to 0.
  - Readies first rise on the first rising edge after deassertion.
  - A reset asserted mid-transaction aborts it: no memory write occurs unless the commit edge already happened, and pending bvalid/rvalid drop immediately.
- Address decode: word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored (unaligned addresses are treated as aligned). Index >= MEM_DEPTH is out of range.
- Write FSM states:
  - WR_IDLE: awready=1 and wready=1. AW and W may handshake in the same cycle or in either order.
  - An accepted channel latches its payload and drops its ready the next cycle until the other channel arrives.
  - When both are held (or arrive together), the write commits on that edge and the FSM moves to WR_RESP.
  - Commit: for each strobe bit i = 1, byte i of mem[index] = wdata byte i. Strobe 0 leaves the word unchanged with an OKAY response.
  - An out-of-range address performs no write and sets bresp=1.
  - WR_RESP: bvalid=1, readies=0. bresp and bvalid stay stable until bready=1; then return to WR_IDLE.
  - Back-to-back capacity: the next AW/W can be accepted the cycle after the B handshake.
  - Minimum latency: both handshakes at edge N give bvalid=1 in cycle N+1. If bready is held at 1, the next accept is at edge N+2.
- Read FSM states:
  - RD_IDLE: arready=1. On an AR handshake, rdata is registered from mem[index] and the FSM moves to RD_DATA.
  - Out of range: rdata=0, rresp=1.
  - RD_DATA: rvalid=1, arready=0. rdata and rresp stay stable until rready=1; then return to RD_IDLE.
  - Read latency: AR at edge N gives rvalid=1 in cycle N+1.
- Simultaneous read and write:
  - The channels are fully independent.
  - If a write commit and an AR accept to the same index fall on the same edge, the read returns the pre-write (old) data.
  - A read accepted on any later edge sees the new data.
- VALID/READY protocol:
  - bvalid and rvalid never depend combinationally on bready or rready.
  - No ready waits on a valid. Readies are registered and asserted in the idle states.

Decomposition:
- Shared package: RESP_OKAY=1'b0 and RESP_SLVERR=1'b1, the write and read FSM state encodings, and a function computing the word index from the byte address.
- Natural sub-module: axi_lite_mem_array. It holds the storage with byte-enable write, a synchronous read port, and asynchronous clear.
- The top level holds the two FSMs and the decode logic.

Test Plan:
- Reset then idle: during reset all outputs are 0. One edge after release, awready=wready=arready=1. A read of 0x00 returns rdata=0, rresp=0.
- Aligned write/read: AW=0x08 and W=0xDEADBEEF (strb 0xF) in the same cycle give bvalid=1 next cycle with bresp=0. A read of 0x08 then returns 0xDEADBEEF with rvalid one cycle after AR.
- Strobes and ordering: W=0x11223344 (strb 0x5) presented 3 cycles before AW=0x08 over prior 0xDEADBEEF. The read returns 0xDE22BE44. wready stays low while waiting for AW.
- Backpressure: hold bready=0 and rready=0 for 5 cycles. bvalid/rvalid, bresp/rresp and rdata stay constant, no new AW/AR is accepted, and the handshake completes when ready rises.
- Error path: AW=0x40 (index 16 with MEM_DEPTH=16) gives bresp=1 and no memory change. AR=0xFC gives rresp=1, rdata=0.
- Collision and reset abort:
  - Write 0xA5A5A5A5 to 0x04 commits on the same edge as an AR to 0x04: the read returns the old value 0, and a second read returns 0xA5A5A5A5.
  - Assert reset while bvalid=1: bvalid drops immediately and memory reads 0 afterwards.
